irq_ctrl: RTL

Interrupt sequencer feeding the CSR block. It captures external, timer and ecall events into a pending register and drives the CSR mip update port (`pending`/`mip_in`). It arbitrates pending events against the mie enables and, at a safe pipeline boundary, emits the `interrupt`/`interrupt_EX` pulses that make the CSR save `mepc` and clear global MIE. On `mret` it returns to idle and supplies the MIE restore value.

---
 rtl/irq_ctrl_if.sv | 33 +++
 rtl/irq_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt sequencer and the core (decode, CSR, fetch redirect).
// The sequencer uses the slave modport; the core side uses master.
interface irq_ctrl_if;
  logic        ext_irq;
  logic        timer_int;
  logic        ecall;
  logic        mret;
  logic [3:0]  mie;
  logic        pipe_ready;
  logic [31:0] pc_ex;
  logic        pending;
  logic [2:0]  mip_in;
  logic        interrupt;
  logic        interrupt_EX;
  logic        mie_in;
  logic [31:0] pc_save;
  logic        flush;
  logic [31:0] vector;
  logic [1:0]  cause;
  logic        notServiced;

  modport master (
    output ext_irq, timer_int, ecall, mret, mie, pipe_ready, pc_ex,
    input  pending, mip_in, interrupt, interrupt_EX, mie_in, pc_save,
           flush, vector, cause, notServiced
  );

  modport slave (
    input  ext_irq, timer_int, ecall, mret, mie, pipe_ready, pc_ex,
    output pending, mip_in, interrupt, interrupt_EX, mie_in, pc_save,
           flush, vector, cause, notServiced
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt sequencer: latches ext/timer/ecall events, arbitrates them against mie,
// and issues the take / MIE-clear pulses to the CSR block at a safe pipeline boundary.
//
// state   | meaning
// IDLE    | nothing eligible, or waiting for events after mret
// PEND    | eligible event present, waiting for pipe_ready
// TAKE    | one-cycle take: interrupt/flush high, pend[cause] cleared
// HANDLER | handler running; first cycle drives interrupt_EX, exit on mret
module irq_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic       clk,
  input  logic       rst,
  irq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PEND    = 2'd1;
  localparam logic [1:0] TAKE    = 2'd2;
  localparam logic [1:0] HANDLER = 2'd3;

  logic [1:0]  state, state_next;
  logic        sync1, sync2, sync2_d;
  logic        ext_rise;
  logic [2:0]  pend, pend_set, pend_clr, pend_next;
  logic [2:0]  eligible;
  logic [1:0]  cause_sel, cause_q;
  logic [31:0] vector_q, pc_save_q;
  logic        ex_q;
  logic        take_go;

  // Two-flop synchronizer plus edge flop; edge flop resetting to 0 makes a line
  // already high at reset release count as one event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= bus.ext_irq;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign ext_rise = sync2 & ~sync2_d;

  assign eligible = pend & bus.mie[2:0] & {3{bus.mie[3]}};

  always_comb begin
    cause_sel = 2'd0;
    if (eligible[2])      cause_sel = 2'd2;
    else if (eligible[1]) cause_sel = 2'd1;
  end

  assign pend_set  = {ext_rise, bus.timer_int, bus.ecall};
  assign pend_clr  = (state == TAKE) ? (3'b001 << cause_q) : 3'b000;
  // Set beats clear so a level timer still high at the take stays pending.
  assign pend_next = (pend & ~pend_clr) | pend_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= 3'b000;
    else      pend <= pend_next;
  end

  assign take_go = (state == PEND) && (eligible != 3'b000) && bus.pipe_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (eligible != 3'b000) state_next = PEND;
      PEND: begin
        if (eligible == 3'b000)  state_next = IDLE;
        else if (bus.pipe_ready) state_next = TAKE;
      end
      TAKE:    state_next = HANDLER;
      HANDLER: if (bus.mret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ex_q      <= 1'b0;
      cause_q   <= 2'd0;
      vector_q  <= VEC_BASE;
      pc_save_q <= 32'd0;
    end else begin
      state <= state_next;
      ex_q  <= (state == TAKE);
      if (take_go) begin
        cause_q   <= cause_sel;
        vector_q  <= VEC_BASE + {28'd0, cause_sel, 2'b00};
        pc_save_q <= bus.pc_ex;
      end
    end
  end

  assign bus.pending      = (pend_next != pend);
  assign bus.mip_in       = pend_next;
  assign bus.interrupt    = (state == TAKE);
  assign bus.flush        = (state == TAKE);
  assign bus.interrupt_EX = ex_q;
  assign bus.mie_in       = ex_q ? 1'b0 : bus.mret;
  assign bus.pc_save      = pc_save_q;
  assign bus.vector       = vector_q;
  assign bus.cause        = cause_q;
  assign bus.notServiced  = pend[1];

endmodule
